seq_gen_moore: RTL and testbench
================================

Name: seq_gen_moore

Overview:
- Serial pattern generator (transmit side) for the team's bit-serial sequence detectors.
- Loads a WIDTH-bit pattern and a repeat count, then drives the pattern MSB-first onto a 1-bit serial line, one bit per clock.
- Optional fixed-length zero gap between repetitions.
- Moore-style FSM with registered outputs; used as stimulus source and loopback partner for the serial detector blocks.

Parameters:
- WIDTH, 4, pattern length in bits (>=2).
- CNT_W, 4, width of the repeat-count input.
- GAP, 1, number of zero bits inserted between consecutive repetitions (0 = back-to-back).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-low (rst=0 resets).
- start  input  1  request; sampled only in IDLE.
- pattern  input  WIDTH  pattern to send, bit WIDTH-1 transmitted first.
- reps  input  CNT_W  number of repetitions (0..2^CNT_W-1).
- x  output  1  serial data, registered.
- x_valid  output  1  high while x carries a stream bit (pattern or gap bit).
- busy  output  1  high from the first stream bit through the last.
- done  output  1  one-cycle pulse after the stream ends.

Behaviour:
- Reset (rst=0, any time, asynchronous): state IDLE; x=0, x_valid=0, busy=0, done=0; shift register, bit counter, rep counter and gap counter cleared. A reset mid-stream aborts the stream immediately with no done pulse.
- States:
  - IDLE: outputs 0. At an edge with start=1, capture pattern and reps. If reps!=0, go to SHIFT; if reps==0, go to DONE.
  - SHIFT: x=shreg[WIDTH-1], x_valid=1, busy=1. Shift left each edge; bit counter counts WIDTH-1..0.
  - End of SHIFT (last bit): decrement the rep counter.
    - If remaining reps>0 and GAP>0, go to GAP.
    - If remaining reps>0 and GAP==0, reload shreg from the captured pattern and stay in SHIFT.
    - If remaining reps==0, go to DONE.
  - GAP: x=0, x_valid=1, busy=1 for exactly GAP cycles, then reload shreg and go to SHIFT.
  - DONE: done=1, busy=0, x_valid=0, x=0 for exactly one cycle, then IDLE.
- Latency: start sampled at edge k gives the first bit (pattern[WIDTH-1]) in the cycle after edge k. No bubbles inside the stream.
- Stream length: reps*WIDTH + (reps-1)*GAP cycles of x_valid=1. done is asserted in the cycle immediately after the last valid bit.
- Captured values: pattern and reps changes after capture are ignored. start is ignored in SHIFT, GAP and DONE; it is not queued. start held high continuously re-triggers from IDLE one cycle after done.
- reps==0: no valid bits; done pulses in the cycle after start.
- Max reps (2^CNT_W-1): the rep counter must not wrap; the stream stops after exactly that many repetitions.
- All outputs are decoded from registered state or flop-driven (Moore); no combinational path from start, pattern or reps to any output.

Test Plan:
- Reset then start=1 for 1 cycle, pattern=4'b1010, reps=1, GAP=1 -> x=1,0,1,0 with x_valid=1 in cycles 1-4 after start; done=1 in cycle 5; busy=0 in cycle 5; IDLE from cycle 6.
- pattern=4'b1010, reps=2, GAP=1 -> x=1,0,1,0,0,1,0,1,0 over 9 valid cycles, then a single done pulse; busy high for exactly 9 cycles.
- reps=0, start=1 -> x_valid never asserts; done=1 in the cycle after start; busy stays 0.
- Mid-stream: pulse start again and change pattern/reps during SHIFT -> stream unchanged, no second stream. Drive rst=0 at bit 2 -> x, x_valid, busy drop to 0 immediately (before the next edge); no done; start after rst=1 works normally.
- GAP=0, pattern=4'b0101, reps=2, looped into the existing overlapping "101" Moore detector -> stream 0,1,0,1,0,1,0,1; detector output asserts 3 times.
- reps=4'hF, pattern=4'b1000, GAP=0 -> exactly 60 valid bits with 15 ones at every 4th bit; done once; no extra repetition (counter wrap check).

Source files
------------

// File: rtl/seq_gen_moore.sv
// seq_gen_moore
//   Bit-serial pattern generator. On start it captures a WIDTH-bit pattern
//   and a repeat count, then sends the pattern MSB-first, one bit per clock,
//   `reps` times. GAP zero bits are inserted between repetitions.
//   Moore FSM; every output comes straight from a flop.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   start    in   request, sampled only while idle
//   pattern  in   [WIDTH-1:0] pattern, bit WIDTH-1 sent first
//   reps     in   [CNT_W-1:0] number of repetitions (0 = no stream)
//   x        out  serial data
//   x_valid  out  x carries a stream bit (pattern or gap bit)
//   busy     out  high from the first stream bit through the last
//   done     out  one-cycle pulse in the cycle after the last stream bit
module seq_gen_moore #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  // With GAP == 0 the GAP state is unreachable; the value only has to be legal.
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : GAP_W'(0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   pat_q,   pat_d;
  logic [BIT_W-1:0]   bit_q,   bit_d;
  logic [CNT_W-1:0]   rep_q,   rep_d;
  logic [GAP_W-1:0]   gap_q,   gap_d;
  logic               x_q,     x_d;
  logic               valid_q, valid_d;
  logic               done_q,  done_d;

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      pat_q   <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      pat_q   <= pat_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    pat_d   = pat_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    gap_d   = gap_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d   = pattern;
          shreg_d = pattern;
          rep_d   = reps;
          bit_d   = BIT_LAST;
          if (reps != CNT_W'(0)) begin
            state_d = S_SHIFT;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        if (bit_q != BIT_W'(0)) begin
          bit_d = bit_q - BIT_W'(1);
        end else begin
          // Last bit of this repetition. rep_q is never 0 here, so the
          // decrement cannot wrap even when reps was the maximum value.
          rep_d = rep_q - CNT_W'(1);
          bit_d = BIT_LAST;
          if (rep_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end else if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LAST;
          end else begin
            shreg_d = pat_q;
          end
        end
      end

      S_GAP: begin
        if (gap_q != GAP_W'(0)) begin
          gap_d = gap_q - GAP_W'(1);
        end else begin
          shreg_d = pat_q;
          bit_d   = BIT_LAST;
          state_d = S_SHIFT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the output flops line up with state_q.
  always_comb begin
    x_d     = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      S_SHIFT: begin
        x_d     = shreg_d[WIDTH-1];
        valid_d = 1'b1;
      end
      S_GAP: begin
        valid_d = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        x_d = 1'b0;
      end
    endcase
  end

  assign x       = x_q;
  assign x_valid = valid_q;
  assign busy    = valid_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_gen_moore.sv
// Directed testbench for seq_gen_moore. Two instances share clock and reset:
// u_g1 with GAP=1 and u_g0 with GAP=0. Inputs are driven and outputs sampled
// on the falling edge. Per-cycle expectations are packed {x,x_valid,busy,done}.
module tb_seq_gen_moore;

  logic       clk = 1'b0;
  logic       rst;
  logic       st1, st0;
  logic [3:0] pat1, pat0;
  logic [3:0] reps1, reps0;
  logic       x1, xv1, busy1, done1;
  logic       x0, xv0, busy0, done0;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seq_gen_moore #(.WIDTH(4), .CNT_W(4), .GAP(1)) u_g1 (
    .clk(clk), .rst(rst), .start(st1), .pattern(pat1), .reps(reps1),
    .x(x1), .x_valid(xv1), .busy(busy1), .done(done1)
  );

  seq_gen_moore #(.WIDTH(4), .CNT_W(4), .GAP(0)) u_g0 (
    .clk(clk), .rst(rst), .start(st0), .pattern(pat0), .reps(reps0),
    .x(x0), .x_valid(xv0), .busy(busy0), .done(done0)
  );

  task automatic test_reset();
    rst = 1'b0; st1 = 1'b0; st0 = 1'b0;
    pat1 = 4'h0; pat0 = 4'h0; reps1 = 4'h0; reps0 = 4'h0;
    @(negedge clk);
    total++;
    if ({x1, xv1, busy1, done1, x0, xv0, busy0, done0} !== 8'h00)
      $display("FAIL reset outputs got %b expected 00000000",
               {x1, xv1, busy1, done1, x0, xv0, busy0, done0});
    else passed++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [3:0] e [1:6] = '{4'b1110, 4'b0110, 4'b1110, 4'b0110, 4'b0001, 4'b0000};
    st1 = 1'b1; pat1 = 4'b1010; reps1 = 4'd1;
    @(negedge clk);
    st1 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      total++;
      if ({x1, xv1, busy1, done1} !== e[c])
        $display("FAIL single cyc%0d got %b expected %b", c, {x1, xv1, busy1, done1}, e[c]);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_two_reps();
    logic [8:0] s = 9'b101001010;
    logic [3:0] exp_v;
    st1 = 1'b1; pat1 = 4'b1010; reps1 = 4'd2;
    @(negedge clk);
    st1 = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c <= 9)       exp_v = {s[9 - c], 3'b110};
      else if (c == 10) exp_v = 4'b0001;
      else              exp_v = 4'b0000;
      total++;
      if ({x1, xv1, busy1, done1} !== exp_v)
        $display("FAIL two_reps cyc%0d got %b expected %b", c, {x1, xv1, busy1, done1}, exp_v);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_reps_zero();
    st1 = 1'b1; pat1 = 4'b1111; reps1 = 4'd0;
    @(negedge clk);
    st1 = 1'b0;
    total++;
    if ({x1, xv1, busy1, done1} !== 4'b0001)
      $display("FAIL reps0 cyc1 got %b expected 0001", {x1, xv1, busy1, done1});
    else passed++;
    @(negedge clk);
    total++;
    if ({x1, xv1, busy1, done1} !== 4'b0000)
      $display("FAIL reps0 cyc2 got %b expected 0000", {x1, xv1, busy1, done1});
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_mid_stream();
    logic [3:0] e [1:9] = '{4'b1110, 4'b1110, 4'b0110, 4'b0110, 4'b0001,
                            4'b0000, 4'b0000, 4'b0000, 4'b0000};
    // Re-request and change captured inputs during SHIFT: must be ignored.
    st1 = 1'b1; pat1 = 4'b1100; reps1 = 4'd1;
    @(negedge clk);
    st1 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      total++;
      if ({x1, xv1, busy1, done1} !== e[c])
        $display("FAIL midstream cyc%0d got %b expected %b", c, {x1, xv1, busy1, done1}, e[c]);
      else passed++;
      if (c == 1) begin st1 = 1'b1; pat1 = 4'b0011; reps1 = 4'd3; end
      if (c == 2) begin st1 = 1'b0; end
      @(negedge clk);
    end

    // Asynchronous reset at the second stream bit.
    st1 = 1'b1; pat1 = 4'b1010; reps1 = 4'd1;
    @(negedge clk);
    st1 = 1'b0;
    @(negedge clk);
    total++;
    if ({x1, xv1, busy1, done1} !== 4'b0110)
      $display("FAIL abort bit2 got %b expected 0110", {x1, xv1, busy1, done1});
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if ({x1, xv1, busy1, done1} !== 4'b0000)
      $display("FAIL abort immediate got %b expected 0000", {x1, xv1, busy1, done1});
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({x1, xv1, busy1, done1} !== 4'b0000)
        $display("FAIL abort no_done cyc%0d got %b expected 0000", c, {x1, xv1, busy1, done1});
      else passed++;
    end
    // Normal operation after reset release.
    st1 = 1'b1; pat1 = 4'b0110; reps1 = 4'd1;
    @(negedge clk);
    st1 = 1'b0;
    total++;
    if ({x1, xv1, busy1, done1} !== 4'b0110)
      $display("FAIL post_reset cyc1 got %b expected 0110", {x1, xv1, busy1, done1});
    else passed++;
    @(negedge clk);
    total++;
    if ({x1, xv1, busy1, done1} !== 4'b1110)
      $display("FAIL post_reset cyc2 got %b expected 1110", {x1, xv1, busy1, done1});
    else passed++;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    // start held high: stream, done, one idle cycle, then the next stream.
    st1 = 1'b1; pat1 = 4'b1010; reps1 = 4'd1;
    @(negedge clk);
    for (int c = 1; c <= 7; c++) begin
      if (c == 5) begin
        total++;
        if ({x1, xv1, busy1, done1} !== 4'b0001)
          $display("FAIL b2b done got %b expected 0001", {x1, xv1, busy1, done1});
        else passed++;
      end
      if (c == 6) begin
        total++;
        if ({x1, xv1, busy1, done1} !== 4'b0000)
          $display("FAIL b2b idle got %b expected 0000", {x1, xv1, busy1, done1});
        else passed++;
      end
      if (c == 7) begin
        total++;
        if ({x1, xv1, busy1, done1} !== 4'b1110)
          $display("FAIL b2b restart got %b expected 1110", {x1, xv1, busy1, done1});
        else passed++;
        st1 = 1'b0;
      end
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_gap0_detector();
    logic [7:0] s = 8'b01010101;
    logic [1:0] hist = 2'b00;
    int hits = 0;
    st0 = 1'b1; pat0 = 4'b0101; reps0 = 4'd2;
    @(negedge clk);
    st0 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      total++;
      if ({x0, xv0, busy0} !== {s[8 - c], 2'b11})
        $display("FAIL gap0 cyc%0d got %b expected %b", c, {x0, xv0, busy0}, {s[8 - c], 2'b11});
      else passed++;
      // Overlapping "101" detector fed by the valid stream bits.
      if (xv0) begin
        if ({hist, x0} == 3'b101) hits++;
        hist = {hist[0], x0};
      end
      @(negedge clk);
    end
    total++;
    if ({xv0, busy0, done0} !== 3'b001)
      $display("FAIL gap0 done got %b expected 001", {xv0, busy0, done0});
    else passed++;
    total++;
    if (hits != 3)
      $display("FAIL gap0 detector hits got %0d expected 3", hits);
    else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_max_reps();
    int nvalid = 0, nones = 0, ndone = 0, nbad = 0, done_cyc = 0;
    st0 = 1'b1; pat0 = 4'b1000; reps0 = 4'hF;
    @(negedge clk);
    st0 = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (xv0) begin
        if (x0 !== ((nvalid % 4) == 0)) nbad++;
        if (x0) nones++;
        nvalid++;
      end
      if (done0) begin
        ndone++;
        done_cyc = c;
      end
      @(negedge clk);
    end
    total++;
    if (nvalid != 60) $display("FAIL max valid_bits got %0d expected 60", nvalid);
    else passed++;
    total++;
    if (nones != 15) $display("FAIL max ones got %0d expected 15", nones);
    else passed++;
    total++;
    if (nbad != 0) $display("FAIL max bit_pattern got %0d bad bits expected 0", nbad);
    else passed++;
    total++;
    if (ndone != 1) $display("FAIL max done_count got %0d expected 1", ndone);
    else passed++;
    total++;
    if (done_cyc != 61) $display("FAIL max done_cycle got %0d expected 61", done_cyc);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_reps();
    test_reps_zero();
    test_mid_stream();
    test_back_to_back();
    test_gap0_detector();
    test_max_reps();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
